// File: rtl/ysyx_22040895_ifu_pkg.sv
// ysyx_22040895_ifu_pkg: shared fetch-stage types, widths and opcode constants
package ysyx_22040895_ifu_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;
  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam int IMM1_LEN = 12;
  localparam int IMM2_LEN = 20;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
endpackage

// File: rtl/ysyx_22040895_predec.sv
// ysyx_22040895_predec: raw immediate fields and immediate select feeding sext
module ysyx_22040895_predec
  import ysyx_22040895_ifu_pkg::*;
(
  input  logic [31:0]         inst,
  output logic [IMM1_LEN-1:0] imm1,
  output logic [IMM2_LEN-1:0] imm2,
  output logic                immsel
);
  // U-type (LUI/AUIPC) selects the 20-bit immediate, everything else the 12-bit one
  always_comb begin
    imm1 = inst[31:20];
    imm2 = inst[31:12];
    immsel = !(inst[6:0] == OP_LUI || inst[6:0] == OP_AUIPC);
  end
endmodule

// File: rtl/ysyx_22040895_ifu.sv
// ysyx_22040895_ifu: single-outstanding instruction fetch with a one-entry output buffer
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [ILEN-1:0]     imem_rdata_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [ILEN-1:0]     inst_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [IMM1_LEN-1:0] imm1_o,
  output logic [IMM2_LEN-1:0] imm2_o,
  output logic                immsel_o
);
  state_t state;
  logic [XLEN-1:0] pc;
  assign imem_req_o = state == S_REQ && !rst;
  assign imem_addr_o = pc;
  // fetch FSM; a redirect overrides everything and turns any in-flight request into a drop
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      state <= S_REQ;
      inst_valid_o <= 1'b0;
      inst_o <= '0;
      pc_o <= '0;
    end else if (redirect_i) begin
      pc <= redirect_pc_i & ~XLEN'(3);
      inst_valid_o <= 1'b0;
      state <= state == S_REQ ? (imem_gnt_i ? S_DROP : S_REQ) :
               state == S_HOLD ? S_REQ : (imem_rvalid_i ? S_REQ : S_DROP);
    end else begin
      case (state)
        S_REQ: if (imem_gnt_i) state <= S_WAIT;
        S_WAIT: if (imem_rvalid_i) begin
          inst_o <= imem_rdata_i;
          pc_o <= pc;
          inst_valid_o <= 1'b1;
          pc <= pc + XLEN'(4);
          state <= S_HOLD;
        end
        S_HOLD: if (inst_ready_i && inst_valid_o) begin
          inst_valid_o <= 1'b0;
          state <= S_REQ;
        end
        default: if (imem_rvalid_i) state <= S_REQ;
      endcase
    end
  end
  ysyx_22040895_predec u_predec (
    .inst(inst_o[31:0]),
    .imm1(imm1_o),
    .imm2(imm2_o),
    .immsel(immsel_o)
  );
endmodule
